// File: rtl/mipi_phy_pkg.sv
// Shared definitions for the MIPI D-PHY link: FSM states, sync byte, LP line codes.
package mipi_phy_pkg;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS_PRPR,
        ST_HST,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_10 = 2'b10;

    // True when v differs from the sync byte in exactly one bit position.
    function automatic logic near_sync(input logic [7:0] v);
        return $countones(v ^ SYNC_BYTE) == 1;
    endfunction

endpackage

// File: rtl/mipi_lp_filt.sv
// LP line conditioning: 2-FF synchronizer followed by a run-length glitch filter.
// The output code changes only after LP_FILT consecutive identical synchronized samples.
module mipi_lp_filt #(
    parameter int LP_FILT = 4
) (
    input  logic       clk_ser,
    input  logic       resetb,
    input  logic [1:0] lp_async,
    output logic [1:0] lp
);
    import mipi_phy_pkg::*;

    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] prev_q;
    logic [1:0] lp_q;
    logic [3:0] run_q;
    logic [4:0] run_n;
    logic       stable;

    // run_n is the length of the current run of equal samples, including this one
    always_comb begin
        run_n  = (sync_q == prev_q) ? ({1'b0, run_q} + 5'd1) : 5'd1;
        stable = (run_n >= 5'(LP_FILT));
    end

    always_ff @(posedge clk_ser or negedge resetb) begin
        if (!resetb) begin
            meta_q <= LP_11;
            sync_q <= LP_11;
            prev_q <= LP_11;
            lp_q   <= LP_11;
            run_q  <= 4'(LP_FILT);
        end else begin
            meta_q <= lp_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
            run_q  <= stable ? 4'(LP_FILT) : run_n[3:0];
            if (stable) begin
                lp_q <= sync_q;
            end
        end
    end

    assign lp = lp_q;

endmodule

// File: rtl/mipi_phy_deser.sv
// Single-lane MIPI D-PHY HS receive deserializer with LP-based SoT/EoT detection.
// Define MIPI_PHY_DESER_SYNC_TOL_EN to also accept a sync byte with a single bit error.
module mipi_phy_deser
    import mipi_phy_pkg::*;
#(
    parameter int NUM_DATA_LANES = 1,
    parameter int LP_FILT        = 4,
    parameter int SYNC_TIMEOUT   = 64,
    parameter int TRAIL_DROP     = 2
) (
    input  logic       clk_ser,
    input  logic       resetb,
    input  logic       enable,
    input  logic       mdp,
    input  logic       mdp_lp,
    input  logic       mdn_lp,
    output logic [7:0] data,
    output logic       we,
    output logic       active,
    output logic       eot,
    output logic       sot_err,
    output logic       sync_soft_err,
    output state_t     fsm_state
);

    localparam int BUF_D = (TRAIL_DROP == 0) ? 1 : TRAIL_DROP;

    if (NUM_DATA_LANES != 1) begin : g_lane_check
        $error("mipi_phy_deser supports exactly one data lane");
    end

    logic [1:0] lp;

    mipi_lp_filt #(.LP_FILT(LP_FILT)) u_lp_filt (
        .clk_ser  (clk_ser),
        .resetb   (resetb),
        .lp_async ({mdp_lp, mdn_lp}),
        .lp       (lp)
    );

    state_t     state_q, state_n;
    logic [7:0] sync_q, sync_n;
    logic [9:0] tmo_q, tmo_n;
    logic [2:0] bit_q, bit_n;
    logic [7:0] byte_q, byte_n;
    logic [2:0] cnt_q, cnt_n;
    logic [7:0] buf_q [BUF_D];
    logic [7:0] buf_n [BUF_D];
    logic [7:0] data_q, data_n;
    logic       we_q, we_n;
    logic       active_q, active_n;
    logic       eot_q, eot_n;
    logic       sot_q, sot_n;
    logic       soft_q, soft_n;

    logic [7:0] sync_shift;
    logic [7:0] byte_shift;
    logic       sync_ok;
    logic       soft_hit;

    // First received bit ends up in bit 0 of both shift registers
    assign sync_shift = {mdp, sync_q[7:1]};
    assign byte_shift = {mdp, byte_q[7:1]};

`ifdef MIPI_PHY_DESER_SYNC_TOL_EN
    assign sync_ok  = (sync_shift == SYNC_BYTE) || near_sync(sync_shift);
    assign soft_hit = (sync_shift != SYNC_BYTE) && near_sync(sync_shift);
`else
    assign sync_ok  = (sync_shift == SYNC_BYTE);
    assign soft_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state_q;
        sync_n   = sync_q;
        tmo_n    = tmo_q;
        bit_n    = bit_q;
        byte_n   = byte_q;
        cnt_n    = cnt_q;
        buf_n    = buf_q;
        data_n   = data_q;
        we_n     = 1'b0;
        active_n = active_q;
        eot_n    = 1'b0;
        sot_n    = 1'b0;
        soft_n   = 1'b0;

        if (!enable) begin
            state_n  = ST_STOP;
            cnt_n    = '0;
            active_n = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (lp == LP_01) state_n = ST_HS_RQST;
                end
                ST_HS_RQST: begin
                    if (lp == LP_00) begin
                        state_n = ST_HS_PRPR;
                        sync_n  = '0;
                        tmo_n   = '0;
                    end else if (lp == LP_11 || lp == LP_10) begin
                        state_n = ST_STOP;
                    end
                end
                ST_HS_PRPR: begin
                    if (lp == LP_11) begin
                        state_n = ST_STOP;
                    end else begin
                        sync_n = sync_shift;
                        if (sync_ok) begin
                            state_n  = ST_HST;
                            active_n = 1'b1;
                            bit_n    = '0;
                            cnt_n    = '0;
                            soft_n   = soft_hit;
                        end else if (tmo_q >= 10'(SYNC_TIMEOUT - 1)) begin
                            state_n = ST_ERR;
                            sot_n   = 1'b1;
                        end else begin
                            tmo_n = tmo_q + 10'd1;
                        end
                    end
                end
                ST_HST: begin
                    // EoT takes priority over a byte completing in the same cycle
                    if (lp == LP_11) begin
                        state_n  = ST_STOP;
                        eot_n    = 1'b1;
                        active_n = 1'b0;
                        cnt_n    = '0;
                    end else begin
                        byte_n = byte_shift;
                        bit_n  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (TRAIL_DROP == 0) begin
                                data_n = byte_shift;
                                we_n   = 1'b1;
                            end else if (cnt_q == 3'(TRAIL_DROP)) begin
                                data_n = buf_q[0];
                                we_n   = 1'b1;
                                for (int i = 0; i < BUF_D - 1; i++) begin
                                    buf_n[i] = buf_q[i + 1];
                                end
                                buf_n[BUF_D - 1] = byte_shift;
                            end else begin
                                for (int i = 0; i < BUF_D; i++) begin
                                    if (i == int'(cnt_q)) buf_n[i] = byte_shift;
                                end
                                cnt_n = cnt_q + 3'd1;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    if (lp == LP_11) state_n = ST_STOP;
                end
                default: state_n = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_ser or negedge resetb) begin
        if (!resetb) begin
            state_q  <= ST_STOP;
            sync_q   <= '0;
            tmo_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < BUF_D; i++) buf_q[i] <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            active_q <= 1'b0;
            eot_q    <= 1'b0;
            sot_q    <= 1'b0;
            soft_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            sync_q   <= sync_n;
            tmo_q    <= tmo_n;
            bit_q    <= bit_n;
            byte_q   <= byte_n;
            cnt_q    <= cnt_n;
            buf_q    <= buf_n;
            data_q   <= data_n;
            we_q     <= we_n;
            active_q <= active_n;
            eot_q    <= eot_n;
            sot_q    <= sot_n;
            soft_q   <= soft_n;
        end
    end

    assign data          = data_q;
    assign we            = we_q;
    assign active        = active_q;
    assign eot           = eot_q;
    assign sot_err       = sot_q;
    assign sync_soft_err = soft_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_mipi_phy_deser.sv
// Directed bench for mipi_phy_deser (default parameters, LP_FILT=4, TRAIL_DROP=2, SYNC_TIMEOUT=64).
module tb_mipi_phy_deser;
    import mipi_phy_pkg::*;

    logic       clk_ser;
    logic       resetb;
    logic       enable;
    logic       mdp;
    logic       mdp_lp;
    logic       mdn_lp;
    logic [7:0] data;
    logic       we;
    logic       active;
    logic       eot;
    logic       sot_err;
    logic       sync_soft_err;
    state_t     fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int we_events = 0;
    int eot_cnt = 0;
    int sot_cnt = 0;
    int soft_cnt = 0;
    logic [7:0] exp_q[$];

    mipi_phy_deser dut (
        .clk_ser       (clk_ser),
        .resetb        (resetb),
        .enable        (enable),
        .mdp           (mdp),
        .mdp_lp        (mdp_lp),
        .mdn_lp        (mdn_lp),
        .data          (data),
        .we            (we),
        .active        (active),
        .eot           (eot),
        .sot_err       (sot_err),
        .sync_soft_err (sync_soft_err),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    initial begin
        clk_ser = 1'b0;
        forever #5 clk_ser = ~clk_ser;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every we strobe must match the next expected byte
    always @(negedge clk_ser) begin
        if (resetb) begin
            if (we) begin
                we_events++;
                check("sb_expected_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("sb_data", 32'(data), 32'(exp_q.pop_front()));
            end
            if (eot) eot_cnt++;
            if (sot_err) sot_cnt++;
            if (sync_soft_err) soft_cnt++;
        end
    end

    // driver tasks: all driving happens 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk_ser);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mdp = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic set_lp(input logic [1:0] v);
        {mdp_lp, mdn_lp} = v;
    endtask

    task automatic enter_hs();
        logic [7:0] sb;
        sb = SYNC_BYTE;
        set_lp(LP_01);
        repeat (10) send_bit(1'b0);
        set_lp(LP_00);
        repeat (30) send_bit(1'b0);
        send_byte(sb);
    endtask

    task automatic go_stop();
        set_lp(LP_11);
        repeat (10) tick();
    endtask

    initial begin
        int n;
        int eot_before;
        int we_before;
        int sot_before;
        logic left_stop;
        logic [7:0] sb;
        logic [7:0] c3;
        logic [7:0] b9;

        resetb = 1'b0;
        enable = 1'b1;
        mdp    = 1'b0;
        set_lp(LP_11);
        repeat (3) tick();
        check("rst_data", 32'(data), 0);
        check("rst_outputs", 32'({we, active, eot, sot_err, sync_soft_err}), 0);
        check("rst_state", 32'(fsm_state), 32'(ST_STOP));
        resetb = 1'b1;
        repeat (3) tick();

        // entry, sync and byte flow
        sb = SYNC_BYTE;
        set_lp(LP_01);
        n = 0;
        while (fsm_state != ST_HS_RQST && n < 50) begin
            tick();
            n++;
        end
        check("lp_latency", 32'(n), 7);
        repeat (3) tick();
        set_lp(LP_00);
        repeat (30) send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(sb[i]);
        check("pre_sync_active", 32'(active), 0);
        send_bit(sb[7]);
        check("sync_active", 32'(active), 1);
        check("sync_state", 32'(fsm_state), 32'(ST_HST));
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_byte(8'h12);
        send_byte(8'h34);
        check("we_while_filling", 32'(we), 0);
        send_byte(8'h56);
        check("we_byte0", 32'(we), 1);
        check("data_byte0", 32'(data), 32'h12);
        send_byte(8'h78);
        check("data_byte1", 32'(data), 32'h34);
        set_lp(LP_11);
        repeat (6) send_bit(1'b1);
        check("eot_not_yet", 32'(eot), 0);
        send_bit(1'b1);
        check("eot_pulse", 32'(eot), 1);
        check("eot_active", 32'(active), 0);
        tick();
        check("eot_one_cycle", 32'(eot), 0);
        repeat (10) tick();
        check("burst1_we_count", 32'(we_events), 2);
        check("burst1_state", 32'(fsm_state), 32'(ST_STOP));

        // sync hunt timeout
        set_lp(LP_01);
        repeat (10) tick();
        set_lp(LP_00);
        mdp = 1'b0;
        n = 0;
        while (fsm_state != ST_HS_PRPR && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        while (!sot_err && n < 200) begin
            tick();
            n++;
        end
        check("sot_latency", 32'(n), 64);
        check("sot_state", 32'(fsm_state), 32'(ST_ERR));
        go_stop();
        check("err_to_stop", 32'(fsm_state), 32'(ST_STOP));
        check("timeout_no_we", 32'(we_events), 2);

        // short LP glitch must be filtered out
        set_lp(LP_01);
        tick();
        tick();
        set_lp(LP_11);
        left_stop = 1'b0;
        repeat (15) begin
            tick();
            if (fsm_state != ST_STOP) left_stop = 1'b1;
        end
        check("glitch_stays_stop", 32'(left_stop), 0);

        // sync byte with one bit error
        b9 = 8'hB9;
        sot_before = sot_cnt;
        set_lp(LP_01);
        repeat (10) tick();
        set_lp(LP_00);
        repeat (30) send_bit(1'b0);
        send_byte(b9);
`ifdef MIPI_PHY_DESER_SYNC_TOL_EN
        check("tol_lock", 32'(active), 1);
        check("tol_soft_err", 32'(soft_cnt), 1);
        go_stop();
`else
        check("tol_no_lock", 32'(active), 0);
        repeat (80) send_bit(1'b0);
        check("tol_timeout", 32'(sot_cnt - sot_before), 1);
        check("tol_no_soft", 32'(soft_cnt), 0);
        go_stop();
`endif
        check("tol_stop", 32'(fsm_state), 32'(ST_STOP));

        // enable dropped mid-burst
        enter_hs();
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("en_we_byte0", 32'(we), 1);
        check("en_data_byte0", 32'(data), 32'h11);
        enable = 1'b0;
        eot_before = eot_cnt;
        tick();
        check("en_active_off", 32'(active), 0);
        check("en_state", 32'(fsm_state), 32'(ST_STOP));
        we_before = we_events;
        repeat (20) send_bit(1'b1);
        check("en_no_eot", 32'(eot_cnt - eot_before), 0);
        check("en_no_we", 32'(we_events - we_before), 0);
        enable = 1'b1;
        go_stop();

        // LP-11 accepted on the same cycle as the 8th bit of a byte
        c3 = 8'hC3;
        enter_hs();
        send_byte(8'hC1);
        send_byte(8'hC2);
        we_before = we_events;
        eot_before = eot_cnt;
        send_bit(c3[0]);
        set_lp(LP_11);
        for (int i = 1; i < 8; i++) send_bit(c3[i]);
        check("sim_eot", 32'(eot), 1);
        check("sim_we", 32'(we), 0);
        repeat (10) tick();
        check("sim_we_count", 32'(we_events - we_before), 0);
        check("sim_eot_count", 32'(eot_cnt - eot_before), 1);

        // asynchronous reset mid-burst
        enter_hs();
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'hC3);
        check("rst_pre_active", 32'(active), 1);
        check("rst_pre_data", 32'(data), 32'hA5);
        #2;
        resetb = 1'b0;
        #1;
        check("rst_mid_data", 32'(data), 0);
        check("rst_mid_outputs", 32'({we, active, eot, sot_err, sync_soft_err}), 0);
        check("rst_mid_state", 32'(fsm_state), 32'(ST_STOP));
        tick();
        resetb = 1'b1;
        go_stop();

        check("sb_drained", 32'(exp_q.size()), 0);
        check("we_total", 32'(we_events), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
